dp_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 4x4-bit register-file datapath.
- Accepts 16-bit instructions over a valid/ready handshake and decodes each into the datapath's 13-bit ControlWord and 4-bit ConstantIn.
- Sequences multi-cycle operations: iterative shifts, and external-input loads that wait on a data handshake.
- Sits between the instruction source (testbench or fetch unit) and the datapath; owns the register-file write enable.

---
 rtl/dp_pkg.sv | 93 +++++++++
 rtl/dp_decode.sv | 84 ++++++++
 rtl/dp_sequencer.sv | 113 +++++++++++
 tb/tb_dp_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared definitions for the register-file datapath sequencer.
//   - opcode constants and FunctionUnit (FS) codes
//   - ControlWord field bit positions and the idle word
//   - instruction word layout and the sequencer state enumeration
//   - pack_cw(): builds a ControlWord from its fields
package dp_pkg;

  localparam int CW_W    = 13;  // ControlWord width, fixed by the datapath field layout
  localparam int DATA_W  = 4;   // datapath word / immediate width
  localparam int INSTR_W = 16;
  localparam int RA_W    = 2;   // register address width (4 registers)

  // Opcodes; 0xD..0xF are illegal
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_IN   = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;

  // FunctionUnit codes shared with the datapath
  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_SUB  = 4'b0101;
  localparam logic [3:0] FS_AND  = 4'b1000;
  localparam logic [3:0] FS_OR   = 4'b1001;
  localparam logic [3:0] FS_XOR  = 4'b1010;
  localparam logic [3:0] FS_NOT  = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_SHR  = 4'b1101;
  localparam logic [3:0] FS_SHL  = 4'b1110;

  // ControlWord field positions
  localparam int CW_DA_HI = 12;
  localparam int CW_DA_LO = 11;
  localparam int CW_AA_HI = 10;
  localparam int CW_AA_LO = 9;
  localparam int CW_BA_HI = 8;
  localparam int CW_BA_LO = 7;
  localparam int CW_MB    = 6;
  localparam int CW_FS_HI = 5;
  localparam int CW_FS_LO = 2;
  localparam int CW_MD    = 1;
  localparam int CW_NWE   = 0;

  // Idle word: no write, every other field zero
  localparam logic [CW_W-1:0] CW_IDLE = 13'h0001;

  typedef struct packed {
    logic [3:0]        op;
    logic [RA_W-1:0]   da;
    logic [RA_W-1:0]   aa;
    logic [RA_W-1:0]   ba;
    logic [1:0]        rsvd;
    logic [DATA_W-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_WAIT_IN = 2'd3
  } state_e;

  function automatic logic [CW_W-1:0] pack_cw(
    input logic [RA_W-1:0] da,
    input logic [RA_W-1:0] aa,
    input logic [RA_W-1:0] ba,
    input logic            mb,
    input logic [3:0]      fs,
    input logic            md,
    input logic            nwe
  );
    logic [CW_W-1:0] cw;
    cw                     = '0;
    cw[CW_DA_HI:CW_DA_LO]  = da;
    cw[CW_AA_HI:CW_AA_LO]  = aa;
    cw[CW_BA_HI:CW_BA_LO]  = ba;
    cw[CW_MB]              = mb;
    cw[CW_FS_HI:CW_FS_LO]  = fs;
    cw[CW_MD]              = md;
    cw[CW_NWE]             = nwe;
    return cw;
  endfunction

endpackage

// File: rtl/dp_decode.sv
// dp_decode: combinational map from (state, IR) to the datapath controls.
// Ports:
//   state        in   current sequencer state
//   ir           in   instruction register
//   in_valid     in   external data valid (only matters in WAIT_IN)
//   control_word out  13-bit ControlWord
//   constant_in  out  immediate for the datapath B mux (0 when idle)
//   err          out  high during EXEC of an illegal opcode
module dp_decode
  import dp_pkg::*;
(
  input  state_e            state,
  input  instr_t            ir,
  input  logic              in_valid,
  output logic [CW_W-1:0]   control_word,
  output logic [DATA_W-1:0] constant_in,
  output logic              err
);

  logic [RA_W-1:0] aa;
  logic            mb;
  logic [3:0]      fs;
  logic            md;
  logic            nwe;

  // Reserved instruction bits carry no meaning.
  logic unused_rsvd;
  assign unused_rsvd = ^ir.rsvd;

  always_comb begin
    control_word = CW_IDLE;
    constant_in  = '0;
    err          = 1'b0;
    aa           = ir.aa;
    mb           = 1'b0;
    fs           = FS_MOVA;
    md           = 1'b0;
    nwe          = 1'b1;

    case (state)
      ST_EXEC: begin
        nwe = 1'b0;
        case (ir.op)
          OP_NOP:  nwe = 1'b1;
          OP_MOV:  fs = FS_MOVA;
          OP_ADD:  fs = FS_ADD;
          OP_SUB:  fs = FS_SUB;
          OP_AND:  fs = FS_AND;
          OP_OR:   fs = FS_OR;
          OP_XOR:  fs = FS_XOR;
          OP_NOT:  fs = FS_NOT;
          OP_ADDI: begin mb = 1'b1; fs = FS_ADD;  end
          OP_LDI:  begin mb = 1'b1; fs = FS_MOVB; end
          OP_IN:   md = 1'b1;
          // A shift only reaches EXEC with imm = 0: nothing to write.
          OP_SHL:  begin aa = ir.da; fs = FS_SHL; nwe = (ir.imm == '0); end
          OP_SHR:  begin aa = ir.da; fs = FS_SHR; nwe = (ir.imm == '0); end
          default: begin nwe = 1'b1; err = 1'b1; end
        endcase
        control_word = pack_cw(ir.da, aa, ir.ba, mb, fs, md, nwe);
      end

      ST_SHIFT: begin
        // Shift in place: source register is the destination.
        fs           = (ir.op == OP_SHR) ? FS_SHR : FS_SHL;
        control_word = pack_cw(ir.da, ir.da, ir.ba, 1'b0, fs, 1'b0, 1'b0);
      end

      ST_WAIT_IN: begin
        // Hold the idle word until data arrives, then write it in that cycle.
        if (in_valid) begin
          control_word = pack_cw(ir.da, ir.aa, ir.ba, 1'b0, FS_MOVA, 1'b1, 1'b0);
        end
      end

      default: ;
    endcase

    if (state != ST_IDLE) begin
      constant_in = ir.imm;
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle instruction sequencer for the 4x4-bit
// register-file datapath. Accepts one instruction at a time over a
// valid/ready handshake and drives the ControlWord / ConstantIn.
// Ports:
//   clk, nRST          clock (rising edge), asynchronous active-low reset
//   instr/instr_valid  instruction in; instr_ready high only when IDLE
//   in_valid/in_ready  external data handshake for the IN instruction
//   ControlWord        [12:11]DA [10:9]AA [8:7]BA [6]MB [5:2]FS [1]MD [0]nWE
//   ConstantIn         immediate to the datapath B mux
//   busy               not IDLE
//   done               pulse on the final cycle of an instruction
//   err                pulse for an illegal opcode
module dp_sequencer
  import dp_pkg::*;
(
  input  logic               clk,
  input  logic               nRST,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CW_W-1:0]    ControlWord,
  output logic [DATA_W-1:0]  ConstantIn,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e            state_reg, state_next;
  instr_t            ir_reg;
  logic [DATA_W-1:0] cnt_reg, cnt_next;
  instr_t            instr_word;
  logic              accept;

  assign instr_word = instr;
  assign accept     = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_reg <= ST_IDLE;
      ir_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        ir_reg <= instr_word;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    instr_ready = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          if (instr_word.op == OP_IN) begin
            state_next = ST_WAIT_IN;
          end else if ((instr_word.op == OP_SHL || instr_word.op == OP_SHR) &&
                       (instr_word.imm != '0)) begin
            state_next = ST_SHIFT;
            cnt_next   = instr_word.imm;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      ST_SHIFT: begin
        // cnt counts remaining write cycles including this one.
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_WAIT_IN: begin
        if (in_valid) begin
          in_ready   = 1'b1;
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  dp_decode u_decode (
    .state        (state_reg),
    .ir           (ir_reg),
    .in_valid     (in_valid),
    .control_word (ControlWord),
    .constant_in  (ConstantIn),
    .err          (err)
  );

endmodule

// File: tb/tb_dp_sequencer.sv
// Testbench for dp_sequencer: scoreboard of expected per-cycle outputs,
// plus a small register-file datapath model driven by the ControlWord.
module tb_dp_sequencer;

  logic        clk;
  logic        nRST;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] ControlWord;
  logic [3:0]  ConstantIn;
  logic        busy;
  logic        done;
  logic        err;

  logic [3:0]  data_in;
  logic [3:0]  regs [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_accept = 0;

  typedef struct {
    logic [12:0] cw;
    logic [3:0]  ci;
    logic        done;
    logic        err;
    logic        inr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dp_sequencer dut (
    .clk         (clk),
    .nRST        (nRST),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ControlWord (ControlWord),
    .ConstantIn  (ConstantIn),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference function unit
  function automatic logic [3:0] alu(input logic [3:0] fs, input logic [3:0] a, input logic [3:0] b);
    case (fs)
      4'b0000: return a;
      4'b0010: return a + b;
      4'b0101: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~a;
      4'b1100: return b;
      4'b1110: return a << 1;
      4'b1101: return a >> 1;
      default: return a;
    endcase
  endfunction

  // Datapath model: register file written when nWE = 0
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
    end else if (!ControlWord[0]) begin
      regs[ControlWord[12:11]] <= ControlWord[1] ? data_in :
        alu(ControlWord[5:2], regs[ControlWord[10:9]],
            ControlWord[6] ? ConstantIn : regs[ControlWord[8:7]]);
    end
  end

  // Expected single-cycle word for an instruction reaching EXEC
  function automatic logic [12:0] exec_cw(input logic [15:0] v);
    logic [1:0] da, aa, ba;
    logic       z;
    da = v[11:10]; aa = v[9:8]; ba = v[7:6];
    z  = (v[3:0] == 4'h0);
    case (v[15:12])
      4'h1: return {da, aa, ba, 1'b0, 4'b0000, 1'b0, 1'b0};
      4'h2: return {da, aa, ba, 1'b0, 4'b0010, 1'b0, 1'b0};
      4'h3: return {da, aa, ba, 1'b0, 4'b0101, 1'b0, 1'b0};
      4'h4: return {da, aa, ba, 1'b0, 4'b1000, 1'b0, 1'b0};
      4'h5: return {da, aa, ba, 1'b0, 4'b1001, 1'b0, 1'b0};
      4'h6: return {da, aa, ba, 1'b0, 4'b1010, 1'b0, 1'b0};
      4'h7: return {da, aa, ba, 1'b0, 4'b1011, 1'b0, 1'b0};
      4'h8: return {da, aa, ba, 1'b1, 4'b0010, 1'b0, 1'b0};
      4'h9: return {da, aa, ba, 1'b1, 4'b1100, 1'b0, 1'b0};
      4'hB: return {da, da, ba, 1'b0, 4'b1110, 1'b0, z};
      4'hC: return {da, da, ba, 1'b0, 4'b1101, 1'b0, z};
      default: return {da, aa, ba, 1'b0, 4'b0000, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic push_expect(input logic [15:0] v, input int n_wait);
    exp_t       e;
    logic [3:0] op, imm;
    op  = v[15:12];
    imm = v[3:0];
    e.ci = imm; e.err = 1'b0; e.inr = 1'b0; e.done = 1'b0;
    if (op == 4'hA) begin
      for (int k = 0; k < n_wait; k++) begin
        e.cw = 13'h0001;
        sb.push_back(e);
      end
      e.cw   = {v[11:10], v[9:8], v[7:6], 1'b0, 4'b0000, 1'b1, 1'b0};
      e.done = 1'b1;
      e.inr  = 1'b1;
      sb.push_back(e);
    end else if ((op == 4'hB || op == 4'hC) && imm != 4'h0) begin
      for (int k = 0; k < int'(imm); k++) begin
        e.cw   = {v[11:10], v[11:10], v[7:6], 1'b0,
                  (op == 4'hB) ? 4'b1110 : 4'b1101, 2'b00};
        e.done = (k == int'(imm) - 1);
        sb.push_back(e);
      end
    end else begin
      e.cw   = exec_cw(v);
      e.done = 1'b1;
      e.err  = (op >= 4'hD);
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] v, input int n_wait, input logic [3:0] din);
    bit got;
    got         = 0;
    instr       = v;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        push_expect(v, n_wait);
        @(posedge clk); #1;
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    last_accept = cyc;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    if (!got) chk("accept_timeout", 16'h0, 16'h1);
    $display("TXN instr=%04h accepted_cycle=%0d", v, last_accept);
    if (v[15:12] == 4'hA) begin
      repeat (n_wait) begin @(posedge clk); #1; end
      data_in  = din;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = 4'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 16'h0, 16'h1);
    @(posedge clk); #1;
  endtask

  // Monitor: every busy cycle consumes one scoreboard entry
  always @(negedge clk) begin
    if (nRST) begin
      if (busy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 16'h1, 16'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("cw",       16'(ControlWord), 16'(mon_e.cw));
          chk("const_in", 16'(ConstantIn),  16'(mon_e.ci));
          chk("done",     16'(done),        16'(mon_e.done));
          chk("err",      16'(err),         16'(mon_e.err));
          chk("in_ready", 16'(in_ready),    16'(mon_e.inr));
        end
      end else begin
        chk("idle_cw",       16'(ControlWord), 16'h0001);
        chk("idle_done",     16'(done),        16'h0);
        chk("idle_in_ready", 16'(in_ready),    16'h0);
        chk("idle_const",    16'(ConstantIn),  16'h0);
      end
    end
  end

  int t_a;

  initial begin
    nRST        = 1'b0;
    instr       = 16'h0;
    instr_valid = 1'b0;
    in_valid    = 1'b0;
    data_in     = 4'h0;
    #2;
    chk("rst_cw",    16'(ControlWord), 16'h0001);
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_busy",  16'(busy),        16'h0);
    chk("rst_done",  16'(done),        16'h0);
    chk("rst_err",   16'(err),         16'h0);
    @(posedge clk); #1;
    nRST = 1'b1;
    @(posedge clk); #1;

    // in_valid early (outside WAIT_IN) must not be consumed
    in_valid = 1'b1;
    send(16'h9405, 0, 4'h0);           // LDI R1,#5
    t_a = last_accept;
    send(16'h2950, 0, 4'h0);           // ADD R2,R1,R1 (held while busy)
    in_valid = 1'b0;
    chk("thru_ldi_add", 16'(last_accept - t_a), 16'd2);
    wait_idle();
    chk("reg1_ldi", 16'(regs[1]), 16'h5);
    chk("reg2_add", 16'(regs[2]), 16'hA);

    send(16'h9401, 0, 4'h0);           // LDI R1,#1
    send(16'hB403, 0, 4'h0);           // SHL R1 by 3
    wait_idle();
    chk("reg1_shl3", 16'(regs[1]), 16'h8);
    send(16'hB400, 0, 4'h0);           // SHL by 0: no write
    wait_idle();
    chk("reg1_shl0", 16'(regs[1]), 16'h8);

    send(16'hAC00, 4, 4'hC);           // IN R3, data after 4 idle cycles
    wait_idle();
    chk("reg3_in", 16'(regs[3]), 16'hC);

    send(16'hE000, 0, 4'h0);           // illegal opcode
    t_a = last_accept;
    send(16'h9807, 0, 4'h0);           // LDI R2,#7 held while busy
    chk("thru_illegal", 16'(last_accept - t_a), 16'd2);
    wait_idle();
    chk("reg0_illegal", 16'(regs[0]), 16'h0);
    chk("reg2_ldi",     16'(regs[2]), 16'h7);

    send(16'h900F, 0, 4'h0);           // LDI R0,#F
    send(16'hC002, 0, 4'h0);           // SHR R0 by 2
    wait_idle();
    chk("reg0_shr2", 16'(regs[0]), 16'h3);
    send(16'hB80F, 0, 4'h0);           // SHL R2 by 15: wraps to 0
    wait_idle();
    chk("reg2_shl15", 16'(regs[2]), 16'h0);
    chk("sb_drain", 16'(sb.size()), 16'h0);

    // Asynchronous reset in the middle of a long shift
    send(16'hB40A, 0, 4'h0);
    repeat (3) begin @(posedge clk); #1; end
    #1;
    nRST = 1'b0;
    #1;
    chk("arst_cw",    16'(ControlWord), 16'h0001);
    chk("arst_ready", 16'(instr_ready), 16'h1);
    chk("arst_busy",  16'(busy),        16'h0);
    chk("arst_done",  16'(done),        16'h0);
    chk("arst_const", 16'(ConstantIn),  16'h0);
    sb.delete();
    @(posedge clk); #1;
    nRST = 1'b1;
    @(posedge clk); #1;

    send(16'h9403, 0, 4'h0);           // LDI R1,#3 after reset
    wait_idle();
    chk("reg1_post_rst", 16'(regs[1]), 16'h3);
    chk("sb_final", 16'(sb.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
